mm_job_scheduler: RTL and testbench
===================================

# mm_job_scheduler

Round-robin scheduler that shares one `generic_matrix_multiply_unit` instance between `NUM_REQ` requesters, such as the Q/K/V projection and attention-score stages of the transformer datapath. It accepts one job at a time and drives `sel_id` so the top level can mux the winner's A/B operands into the multiply unit. It issues the single-cycle `op_start_mm` pulse, tracks `op_busy_mm`/`op_done_mm`, and returns a one-hot completion pulse (with error flag) to the owning requester once the registered C outputs are stable. It sits between the stage controllers and the shared multiply unit.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16).
- `TIMEOUT_CYCLES`, 1024, maximum cycles from `mm_start` to `mm_done` before the job is aborted with error.
- `ID_W`, `$clog2(NUM_REQ)`, derived; width of `sel_id`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester job request; held high until the matching `req_ready`.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `sel_id`  out  ID_W  index of the current job owner; stable from START through RESP.
- `mm_start`  out  1  to `op_start_mm`; one-cycle pulse.
- `mm_busy`  in  1  from `op_busy_mm`.
- `mm_done`  in  1  from `op_done_mm`.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- `rsp_error`  out  1  qualifies `rsp_valid`; 1 means timeout or protocol error.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, RUN, SETTLE, RESP. All outputs are Moore-decoded from registered state, `sel_id` and the error flag.
- **IDLE**
  - If any `req_valid` is high, the round-robin pick takes the first asserted index scanning from `last_id+1` mod `NUM_REQ`.
  - Load `sel_id` with that index; go to START.
- **START**
  - `req_ready[sel_id]=1` and `mm_start=1`; clear the timeout counter and the error flag.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**
  - `mm_done` high: go to SETTLE (fast completion).
  - Otherwise `mm_busy` high: go to RUN.
- **RUN**
  - `mm_done` high: go to SETTLE.
  - `mm_busy` low with `mm_done` low: set error; go to SETTLE.
- **Timeout:** in WAIT_BUSY or RUN, the counter increments each cycle. Reaching `TIMEOUT_CYCLES-1` without `mm_done` sets error and goes to SETTLE.
- **SETTLE:** one cycle so the registered C outputs become valid; go to RESP.
- **RESP**
  - `rsp_valid[sel_id]=1` and `rsp_error`=error flag; `last_id<=sel_id`.
  - Go to IDLE.
- `req_valid` bits that are not granted are ignored (no queueing). A requester dropping `req_valid` before its grant is legal.
- `mm_done` or `mm_busy` activity seen in IDLE is ignored.

## Timing
- **Reset values:** state IDLE, `sel_id=0`, `last_id=NUM_REQ-1` (so requester 0 has first priority), counter 0, error 0. All outputs are 0.
- **Reset mid-job:** everything returns to the reset values on the next edge. No `rsp_valid` is issued for the aborted job. The multiply unit shares `rst` at top level.
- **Grant latency:** `req_valid` sampled high in IDLE at edge N gives `req_ready` and `mm_start` during cycle N+1 (1 cycle).
- **Completion:** `mm_done` sampled high at edge E puts SETTLE in cycle E+1 and `rsp_valid` in cycle E+2.
- **Back-to-back:** RESP→IDLE→START, so the minimum gap between `mm_start` pulses is job length + 4 cycles.
- **Simultaneous requests:** round-robin, no starvation. With all requests high continuously, grants go 0,1,2,3,0,…
- **Ordering:** `mm_done` arriving in the same cycle `mm_busy` falls is treated as success.
- **Counter width:** `$clog2(TIMEOUT_CYCLES)`; the counter saturates and never wraps.

## Structure
- Package `mm_sched_pkg` holds:
  - the state enum `mm_sched_state_t` (IDLE..RESP);
  - default `TIMEOUT_CYCLES`;
  - function `rr_pick(req, last)` returning the winning index.
- Sub-module `rr_arbiter` (combinational: request vector + last pointer → valid + index) keeps the FSM file small and is reusable by other shared-resource controllers.

## Test plan
- **Single request:** `req_valid=4'b0100`, done 30 cycles after start → `req_ready[2]` and `mm_start` one cycle later; `rsp_valid=4'b0100`, `rsp_error=0` two cycles after `mm_done`.
- **Fairness:** `req_valid=4'b1111` held for 8 jobs → grant order 0,1,2,3,0,1,2,3; exactly one `mm_start` per job.
- **Integration:** real `generic_matrix_multiply_unit` (2x3 · 3x2) with `A=[[1,2,3],[4,5,6]]`, `B=[[7,8],[9,1],[2,3]]` on requester 1 → at `rsp_valid[1]`, C = [[31,19],[85,55]].
- **Timeout:** `TIMEOUT_CYCLES=16`, model never asserts `mm_done` → `rsp_valid[sel_id]` with `rsp_error=1` about 18 cycles after `mm_start`; FSM back to IDLE, next request served normally.
- **Protocol error:** `mm_busy` drops without `mm_done` → `rsp_error=1`.
- **Reset mid-RUN:** `rst` pulsed for one cycle → all outputs 0 next cycle, no `rsp_valid`; requester 0 regains first priority.

Source files
------------

// File: rtl/mm_job_scheduler_pkg.sv
// Shared types and helpers for the matrix-multiply job scheduler.
// rr_pick works on a fixed 16-bit vector so it serves any requester count up to MAX_REQ.
package mm_sched_pkg;

    localparam int unsigned MAX_REQ                = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        SETTLE    = 3'd4,
        RESP      = 3'd5
    } mm_sched_state_t;

    // Unused high request bits are zero, so a mod-16 scan from last+1 visits the set
    // bits in the same order as a mod-NUM_REQ scan would.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [3:0] last);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = last + 4'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mm_job_scheduler_if.sv
// Requester and multiply-unit handshake bundle for mm_job_scheduler.
// slave is the scheduler side; master is the stage controllers / multiply unit side.
interface mm_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [ID_W-1:0]    sel_id;
    logic               mm_start;
    logic               mm_busy;
    logic               mm_done;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               rsp_error;
    logic               busy;

    modport slave (
        input  req_valid, mm_busy, mm_done,
        output req_ready, sel_id, mm_start, rsp_valid, rsp_error, busy
    );

    modport master (
        output req_valid, mm_busy, mm_done,
        input  req_ready, sel_id, mm_start, rsp_valid, rsp_error, busy
    );
endinterface

// File: rtl/mm_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request after the last winner, cyclically.
// Reusable by any controller that shares a single resource among up to 16 clients.
module rr_arbiter
    import mm_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         last_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        last_ext             = 4'(last);
        pick                 = rr_pick(req_ext, last_ext);
        grant_valid          = |req;
        grant_id             = ID_W'(pick);
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// Round-robin owner of one shared matrix-multiply unit: grants a job, pulses the
// start, watches busy/done with a timeout, and returns a one-hot completion to the owner.
module mm_job_scheduler
    import mm_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic               clk,
    input logic               rst,
    mm_job_scheduler_if.slave bus
);

    localparam int unsigned     ID_W     = $clog2(NUM_REQ);
    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    mm_sched_state_t    state_q, state_d;
    logic [ID_W-1:0]    sel_id_q, sel_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               arb_valid;
    logic [ID_W-1:0]    arb_id;
    logic               timed_out;
    logic [NUM_REQ-1:0] sel_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (bus.req_valid),
        .last        (last_id_q),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    assign timed_out = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        sel_id_d  = sel_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    sel_id_d = arb_id;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY, RUN: begin
                // done wins over both timeout and a falling busy in the same cycle
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
                if (bus.mm_done) begin
                    state_d = SETTLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = SETTLE;
                end else if (state_q == WAIT_BUSY) begin
                    if (bus.mm_busy) state_d = RUN;
                end else if (!bus.mm_busy) begin
                    err_d   = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: state_d = RESP;
            RESP: begin
                last_id_d = sel_id_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_id_q  <= '0;
            last_id_q <= LAST_RST;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_id_q  <= sel_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign sel_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id_q;
    assign bus.req_ready = (state_q == START) ? sel_onehot : '0;
    assign bus.mm_start  = (state_q == START);
    assign bus.rsp_valid = (state_q == RESP) ? sel_onehot : '0;
    assign bus.rsp_error = (state_q == RESP) && err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sel_id    = sel_id_q;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Randomized scoreboard bench for mm_job_scheduler with a behavioural multiply-unit model.
module tb_mm_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm_job_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    mm_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int id; int cyc; } grant_t;
    typedef struct { int id; bit err; int cyc; } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     model_last  = NUM_REQ - 1;
    int     cyc         = 0;
    logic   rst_at_edge = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    bit in_job = 0;
    int cur_id = 0;
    always @(negedge clk) begin
        grant_t             g;
        rsp_t               r;
        logic [NUM_REQ-1:0] e;
        bit                 clear_after;
        clear_after = 0;
        if (rst_at_edge) begin
            vectors++;
            if (bus.req_ready != '0 || bus.rsp_valid != '0 || bus.mm_start || bus.rsp_error
                || bus.busy || bus.sel_id != '0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d got ready=%b start=%b rsp=%b err=%b busy=%b sel=%0d, want all zero",
                         cyc, bus.req_ready, bus.mm_start, bus.rsp_valid, bus.rsp_error, bus.busy, bus.sel_id);
            end
            in_job = 0;
        end else begin
            if (bus.req_ready != '0 || bus.mm_start) begin
                vectors++;
                if (gq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_grant cyc=%0d got ready=%b start=%b, want no grant",
                             cyc, bus.req_ready, bus.mm_start);
                end else begin
                    g = gq.pop_front();
                    e = '0;
                    e[g.id] = 1'b1;
                    if (bus.req_ready !== e || bus.mm_start !== 1'b1 || int'(bus.sel_id) != g.id || cyc != g.cyc) begin
                        miscompares++;
                        $display("FAIL grant cyc=%0d got ready=%b start=%b sel=%0d, want ready=%b start=1 sel=%0d at cyc %0d",
                                 cyc, bus.req_ready, bus.mm_start, bus.sel_id, e, g.id, g.cyc);
                    end
                    in_job = 1;
                    cur_id = g.id;
                end
            end else if (gq.size() != 0 && gq[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                g = gq.pop_front();
                $display("FAIL grant_missing cyc=%0d got none, want id %0d at cyc %0d", cyc, g.id, g.cyc);
            end

            if (bus.rsp_valid != '0) begin
                vectors++;
                clear_after = 1;
                if (rq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp cyc=%0d got rsp=%b err=%b, want no response",
                             cyc, bus.rsp_valid, bus.rsp_error);
                end else begin
                    r = rq.pop_front();
                    e = '0;
                    e[r.id] = 1'b1;
                    if (bus.rsp_valid !== e || bus.rsp_error !== r.err || cyc != r.cyc) begin
                        miscompares++;
                        $display("FAIL rsp cyc=%0d got rsp=%b err=%b, want rsp=%b err=%b at cyc %0d",
                                 cyc, bus.rsp_valid, bus.rsp_error, e, r.err, r.cyc);
                    end
                end
            end else begin
                if (rq.size() != 0 && rq[0].cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    r = rq.pop_front();
                    clear_after = 1;
                    $display("FAIL rsp_missing cyc=%0d got none, want id %0d at cyc %0d", cyc, r.id, r.cyc);
                end
                if (bus.rsp_error) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stray_error cyc=%0d got rsp_error=1, want 0 without rsp_valid", cyc);
                end
            end

            vectors++;
            if (bus.busy !== in_job) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got %b, want %b", cyc, bus.busy, in_job);
            end
            if (in_job && int'(bus.sel_id) != cur_id) begin
                miscompares++;
                $display("FAIL sel_stable cyc=%0d got sel=%0d, want %0d", cyc, bus.sel_id, cur_id);
            end
            if (clear_after) in_job = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] mask);
        for (int off = 1; off <= NUM_REQ; off++) begin
            int i;
            i = (model_last + off) % NUM_REQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    // scen: 0 done after len, 1 busy drops at len, 2 never done, 3 done one cycle too late,
    // 4 reset pulsed at len. Called in an IDLE cycle; returns in the RESP (or post-reset) cycle.
    task automatic run_job(input logic [NUM_REQ-1:0] mask, input int scen, input int len, input bit hold);
        int s, idx, rcyc, j;
        bit err, busy_lvl;
        idx            = model_pick(mask);
        bus.req_valid  = mask;
        bus.mm_busy    = 1'($urandom);
        bus.mm_done    = 1'($urandom);
        s              = cyc + 1;
        busy_lvl       = 1'($urandom);
        gq.push_back('{id: idx, cyc: s});
        case (scen)
            0:       begin err = 0; rcyc = s + len + 2;     end
            1:       begin err = 1; rcyc = s + len + 2;     end
            2, 3:    begin err = 1; rcyc = s + TIMEOUT + 2; end
            default: begin err = 0; rcyc = s + len + 1;     end
        endcase
        if (scen != 4) rq.push_back('{id: idx, err: err, cyc: rcyc});
        tick();
        bus.req_valid = hold ? mask : NUM_REQ'($urandom);
        bus.mm_busy   = 1'b0;
        bus.mm_done   = 1'b0;
        while (cyc < rcyc) begin
            tick();
            j = cyc - s;
            if (!hold) bus.req_valid = NUM_REQ'($urandom);
            bus.mm_busy = 1'b0;
            bus.mm_done = 1'b0;
            case (scen)
                0: begin
                    if (j < len) bus.mm_busy = 1'b1;
                    else if (j == len) begin
                        bus.mm_busy = 1'($urandom);
                        bus.mm_done = 1'b1;
                    end
                end
                1: if (j < len) bus.mm_busy = 1'b1;
                2: if (j <= TIMEOUT) bus.mm_busy = busy_lvl;
                3: begin
                    if (j <= TIMEOUT) bus.mm_busy = 1'b1;
                    else if (j == TIMEOUT + 1) bus.mm_done = 1'b1;
                end
                default: begin
                    bus.mm_busy = 1'b1;
                    if (j == len) rst = 1'b1;
                    else if (j == len + 1) rst = 1'b0;
                end
            endcase
        end
        bus.req_valid = '0;
        model_last    = (scen == 4) ? NUM_REQ - 1 : idx;
    endtask

    task automatic between(input int gap);
        for (int g = 0; g <= gap; g++) begin
            tick();
            if (g < gap) begin
                bus.req_valid = '0;
                bus.mm_busy   = 1'($urandom);
                bus.mm_done   = 1'($urandom);
            end
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] m;
        int                 scen, len;
        bus.req_valid = '0;
        bus.mm_busy   = 1'b0;
        bus.mm_done   = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Fairness with all requests held: 0,1,2,3,0,1,2,3.
        for (int n = 0; n < 8; n++) begin
            run_job('1, 0, $urandom_range(1, 12), 1);
            between(0);
        end
        run_job(4'b0100, 0, 30, 0);            between(2);
        run_job(4'b0011, 0, TIMEOUT, 0);       between(1);
        run_job(4'b1000, 0, 1, 0);             between(0);
        run_job(4'b0110, 2, 0, 0);             between(1);
        run_job(4'b1111, 3, 0, 0);             between(0);
        run_job(4'b1001, 1, 5, 0);             between(3);
        run_job(4'b0101, 1, 2, 1);             between(0);
        run_job(4'b1010, 4, 6, 0);             between(1);
        run_job(4'b1111, 0, 3, 0);             between(0);

        for (int n = 0; n < 60; n++) begin
            do m = NUM_REQ'($urandom); while (m == '0);
            scen = $urandom_range(0, 9);
            if (scen > 4) scen = 0;
            case (scen)
                1:       len = $urandom_range(2, TIMEOUT);
                4:       len = $urandom_range(1, TIMEOUT - 1);
                default: len = $urandom_range(1, TIMEOUT);
            endcase
            run_job(m, scen, len, 1'($urandom));
            between($urandom_range(0, 3));
        end

        repeat (5) tick();
        vectors++;
        if (gq.size() != 0 || rq.size() != 0) begin
            miscompares += gq.size() + rq.size();
            $display("FAIL leftover got %0d grants and %0d responses outstanding, want 0 and 0", gq.size(), rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
